// File: rtl/board_renderer.sv
// Walks the board cell memory and streams pixel writes for the VGA plot port.
// Redraws either the whole board (row-major) or one cell, with an optional cursor border.
module board_renderer #(
  parameter int          BOARD_N       = 8,
  parameter int          CELL_PX       = 8,
  parameter int          X0            = 16,
  parameter int          Y0            = 0,
  parameter int          XW            = 8,
  parameter int          YW            = 7,
  parameter logic [2:0]  GRID_COLOUR   = 3'b000,
  parameter logic [2:0]  EMPTY_COLOUR  = 3'b010,
  parameter logic [2:0]  P0_COLOUR     = 3'b000,
  parameter logic [2:0]  P1_COLOUR     = 3'b111,
  parameter logic [2:0]  HINT_COLOUR   = 3'b110,
  parameter logic [2:0]  CURSOR_COLOUR = 3'b100,
  localparam int         IW            = (BOARD_N > 1) ? $clog2(BOARD_N) : 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start_full,
  input  logic          start_cell,
  input  logic [IW-1:0] cell_x,
  input  logic [IW-1:0] cell_y,
  input  logic          cursor_en,
  input  logic [IW-1:0] cursor_x,
  input  logic [IW-1:0] cursor_y,
  output logic [IW-1:0] rd_x,
  output logic [IW-1:0] rd_y,
  input  logic [1:0]    rd_data,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic [2:0]    colour,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  localparam int PW = $clog2(CELL_PX);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAW, S_DONE} state_t;

  typedef struct packed {
    logic          en;
    logic [IW-1:0] x;
    logic [IW-1:0] y;
  } cursor_t;

  state_t        state;
  cursor_t       cur;
  logic          full;
  logic [1:0]    code;
  logic [PW-1:0] px, py, npx, npy;
  logic          last_px, last_pix, last_cell, cur_hit;

  function automatic logic [IW-1:0] clamp(input logic [IW-1:0] v);
    return (int'(v) >= BOARD_N) ? IW'(BOARD_N - 1) : v;
  endfunction

  function automatic logic [XW-1:0] x_at(input logic [IW-1:0] c, input logic [PW-1:0] p);
    return XW'(X0 + int'(c) * CELL_PX + int'(p));
  endfunction

  function automatic logic [YW-1:0] y_at(input logic [IW-1:0] r, input logic [PW-1:0] p);
    return YW'(Y0 + int'(r) * CELL_PX + int'(p));
  endfunction

  // Only the left and top edges are border; the right/bottom neighbour supplies the rest.
  function automatic logic [2:0] pix_colour(input logic [PW-1:0] cx, input logic [PW-1:0] cy,
                                            input logic [1:0] cd, input logic hit);
    if (cx == '0 || cy == '0) return hit ? CURSOR_COLOUR : GRID_COLOUR;
    if (cx >= PW'(2) && cx <= PW'(CELL_PX - 2) && cy >= PW'(2) && cy <= PW'(CELL_PX - 2)) begin
      case (cd)
        2'b01:   return P0_COLOUR;
        2'b10:   return P1_COLOUR;
        2'b11:   return HINT_COLOUR;
        default: return EMPTY_COLOUR;
      endcase
    end
    return EMPTY_COLOUR;
  endfunction

  always_comb begin
    last_px   = (px == PW'(CELL_PX - 1));
    last_pix  = last_px && (py == PW'(CELL_PX - 1));
    last_cell = (rd_x == IW'(BOARD_N - 1)) && (rd_y == IW'(BOARD_N - 1));
    cur_hit   = cur.en && (cur.x == rd_x) && (cur.y == rd_y);
    npx       = last_px ? '0 : px + PW'(1);
    npy       = last_px ? py + PW'(1) : py;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      cur    <= '0;
      full   <= 1'b0;
      code   <= 2'b00;
      px     <= '0;
      py     <= '0;
      rd_x   <= '0;
      rd_y   <= '0;
      x_out  <= '0;
      y_out  <= '0;
      colour <= 3'b000;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_full || start_cell) begin
          state <= S_FETCH;
          busy  <= 1'b1;
          full  <= start_full;
          cur   <= '{en: cursor_en, x: clamp(cursor_x), y: clamp(cursor_y)};
          rd_x  <= start_full ? '0 : clamp(cell_x);
          rd_y  <= start_full ? '0 : clamp(cell_y);
        end
        S_FETCH: state <= S_WAIT;
        // rd_data is live this cycle, so the first pixel uses it directly.
        S_WAIT: begin
          state  <= S_DRAW;
          code   <= rd_data;
          px     <= '0;
          py     <= '0;
          plot   <= 1'b1;
          x_out  <= x_at(rd_x, '0);
          y_out  <= y_at(rd_y, '0);
          colour <= pix_colour('0, '0, rd_data, cur_hit);
        end
        S_DRAW: begin
          if (last_pix) begin
            plot <= 1'b0;
            if (full && !last_cell) begin
              state <= S_FETCH;
              if (rd_x == IW'(BOARD_N - 1)) begin
                rd_x <= '0;
                rd_y <= rd_y + IW'(1);
              end else begin
                rd_x <= rd_x + IW'(1);
              end
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else begin
            px     <= npx;
            py     <= npy;
            x_out  <= x_at(rd_x, npx);
            y_out  <= y_at(rd_y, npy);
            colour <= pix_colour(npx, npy, code, cur_hit);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer at default parameters: reset, single cell,
// disc/cursor, full board, ignored restarts and reset mid-render.
module tb_board_renderer;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       start_full = 1'b0, start_cell = 1'b0;
  logic [2:0] cell_x = '0, cell_y = '0;
  logic       cursor_en = 1'b0;
  logic [2:0] cursor_x = '0, cursor_y = '0;
  logic [2:0] rd_x, rd_y;
  logic [1:0] rd_data;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot, busy, done;

  board_renderer dut (
    .clock(clk), .resetn(resetn), .start_full(start_full), .start_cell(start_cell),
    .cell_x(cell_x), .cell_y(cell_y), .cursor_en(cursor_en), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .x_out(x_out),
    .y_out(y_out), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Board memory, indexed [column][row], one cycle read latency.
  logic [1:0] mem [8][8];
  always @(posedge clk) rd_data <= mem[rd_x][rd_y];

  int e = 0;
  always @(posedge clk) e <= e + 1;

  // Plot monitor: the cycle after edge e is cycle e+1.
  int         pcnt = 0, done_cnt = 0, done_cyc = 0;
  int         pcyc [8192];
  logic [7:0] qx   [8192];
  logic [6:0] qy   [8192];
  logic [2:0] qc   [8192];
  logic [5:0] qa   [8192];
  always @(negedge clk) begin
    if (plot && pcnt < 8192) begin
      pcyc[pcnt] = e + 1;
      qx[pcnt]   = x_out;
      qy[pcnt]   = y_out;
      qc[pcnt]   = colour;
      qa[pcnt]   = {rd_y, rd_x};
      pcnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = e + 1;
    end
  end

  int n_assert = 0, n_fail = 0;
  int k, p0, d0, errs, aerrs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic kick(input logic f, input logic c);
    p0 = pcnt;
    d0 = done_cnt;
    start_full = f;
    start_cell = c;
    k = e + 1;
    tick();
    start_full = 1'b0;
    start_cell = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int n;
    n = 0;
    while (done_cnt == d0 && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(done_cnt > d0), 1);
  endtask

  function automatic logic [2:0] exp_col(input int c, input int r, input int x, input int y,
                                         input logic [1:0] cd, input bit ce, input int cx, input int cy);
    if (x == 0 || y == 0) return (ce && c == cx && r == cy) ? 3'b100 : 3'b000;
    if (x >= 2 && x <= 6 && y >= 2 && y <= 6 && cd != 2'b00)
      return (cd == 2'b01) ? 3'b000 : (cd == 2'b10) ? 3'b111 : 3'b110;
    return 3'b010;
  endfunction

  initial begin
    for (int c = 0; c < 8; c++) for (int r = 0; r < 8; r++) mem[c][r] = 2'b00;

    // Reset with random inputs
    #1 resetn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start_full = 1'($urandom); start_cell = 1'($urandom); cursor_en = 1'($urandom);
      cell_x = 3'($urandom); cell_y = 3'($urandom);
      cursor_x = 3'($urandom); cursor_y = 3'($urandom);
      tick();
    end
    chk("rst_ctl", {29'd0, plot, busy, done}, 0);
    chk("rst_x", 32'(x_out), 0);
    chk("rst_y", 32'(y_out), 0);
    chk("rst_colour", 32'(colour), 0);
    chk("rst_rd", {26'd0, rd_y, rd_x}, 0);
    start_full = 1'b0; start_cell = 1'b0; cursor_en = 1'b0;
    resetn = 1'b1;
    repeat (5) tick();
    chk("post_rst_ctl", {29'd0, plot, busy, done}, 0);
    chk("post_rst_xy", {17'd0, x_out, y_out}, 0);

    // Single cell (0,0), empty, with an ignored start_cell at edge k+10
    cell_x = 3'd0; cell_y = 3'd0;
    kick(1'b0, 1'b1);
    chk("cell_busy", 32'(busy), 1);
    while (e + 1 < k + 10) tick();
    cell_x = 3'd5;
    start_cell = 1'b1;
    tick();
    start_cell = 1'b0;
    wait_done(200, "cell_timeout");
    chk("cell_done_cyc", done_cyc, k + 67);
    chk("cell_first_cyc", pcyc[p0], k + 3);
    chk("cell_last_cyc", pcyc[p0 + 63], k + 66);
    chk("cell_px0", {qx[p0], 1'b0, qy[p0], qc[p0]}, {8'd16, 1'b0, 7'd0, 3'b000});
    chk("cell_px27", {qx[p0 + 27], 1'b0, qy[p0 + 27], qc[p0 + 27]}, {8'd19, 1'b0, 7'd3, 3'b010});
    tick();
    chk("cell_busy_after", 32'(busy), 0);
    repeat (80) tick();
    chk("cell_plot_count", pcnt - p0, 64);
    chk("cell_done_count", done_cnt - d0, 1);

    // Disc and cursor at (7,7); inputs change after latch
    mem[7][7] = 2'b10;
    cell_x = 3'd7; cell_y = 3'd7;
    cursor_en = 1'b1; cursor_x = 3'd7; cursor_y = 3'd7;
    kick(1'b0, 1'b1);
    cell_x = 3'd0; cursor_en = 1'b0;
    wait_done(200, "disc_timeout");
    chk("disc_count", pcnt - p0, 64);
    chk("disc_cursor", {qx[p0], 1'b0, qy[p0], qc[p0]}, {8'd72, 1'b0, 7'd56, 3'b100});
    chk("disc_centre", {qx[p0 + 36], 1'b0, qy[p0 + 36], qc[p0 + 36]}, {8'd76, 1'b0, 7'd60, 3'b111});
    chk("disc_corner", {qx[p0 + 63], 1'b0, qy[p0 + 63], qc[p0 + 63]}, {8'd79, 1'b0, 7'd63, 3'b010});
    chk("disc_top_border", 32'(qc[p0 + 5]), 32'(3'b100));
    tick();

    // Full board, both starts together, cursor at (2,5)
    for (int c = 0; c < 8; c++) for (int r = 0; r < 8; r++) mem[c][r] = 2'((c + r) % 4);
    cursor_en = 1'b1; cursor_x = 3'd2; cursor_y = 3'd5;
    cell_x = 3'd3; cell_y = 3'd3;
    kick(1'b1, 1'b1);
    wait_done(5000, "full_timeout");
    chk("full_count", pcnt - p0, 4096);
    chk("full_done_cyc", done_cyc, k + 4225);
    chk("full_first_cyc", pcyc[p0], k + 3);
    errs = 0; aerrs = 0;
    for (int i = 0; i < 4096; i++) begin
      int cl, c, r, pp, x, y;
      cl = i / 64; c = cl % 8; r = cl / 8; pp = i % 64; x = pp % 8; y = pp / 8;
      if (qx[p0 + i] !== 8'(16 + c * 8 + x) || qy[p0 + i] !== 7'(r * 8 + y) ||
          qc[p0 + i] !== exp_col(c, r, x, y, mem[c][r], 1'b1, 2, 5)) errs++;
      if (pp == 0 && qa[p0 + i] !== {3'(r), 3'(c)}) aerrs++;
    end
    chk("full_pixels", errs, 0);
    chk("full_rd_order", aerrs, 0);
    tick();

    // Reset at plot 100 of a full render
    cursor_en = 1'b0;
    kick(1'b1, 1'b0);
    begin
      int n;
      n = 0;
      while (pcnt - p0 < 100 && n < 500) begin tick(); n++; end
      chk("mid_reach_100", 32'(pcnt - p0 >= 100), 1);
    end
    resetn = 1'b0;
    #1;
    chk("mid_rst_plot", 32'(plot), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_xc", {21'd0, x_out, colour}, 0);
    d0 = done_cnt;
    errs = pcnt;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (3) tick();
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_no_plot", pcnt - errs, 0);

    mem[3][4] = 2'b01;
    cell_x = 3'd3; cell_y = 3'd4;
    kick(1'b0, 1'b1);
    wait_done(200, "after_timeout");
    chk("after_done_cyc", done_cyc, k + 67);
    chk("after_count", pcnt - p0, 64);
    chk("after_px0", {qx[p0], 1'b0, qy[p0], qc[p0]}, {8'd40, 1'b0, 7'd32, 3'b000});
    chk("after_px9", {qx[p0 + 9], 1'b0, qy[p0 + 9], qc[p0 + 9]}, {8'd41, 1'b0, 7'd33, 3'b010});
    chk("after_px18", {qx[p0 + 18], 1'b0, qy[p0 + 18], qc[p0 + 18]}, {8'd42, 1'b0, 7'd34, 3'b000});
    chk("after_px56", {qx[p0 + 56], 1'b0, qy[p0 + 56], qc[p0 + 56]}, {8'd40, 1'b0, 7'd39, 3'b000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
